posit_decoder_pipe: RTL and testbench

//  Pipelined, parametrised posit decoder: next generation of our combinational leading-digit decoder.

---
 rtl/posit_decoder_pipe_if.sv | 38 +++
 rtl/posit_decoder_pipe.sv | 102 ++++++++++
 tb/tb_posit_decoder_pipe.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/posit_decoder_pipe_if.sv
// posit_decoder_pipe_if: input/output handshake bundle for the posit decoder.
// out_scale exists only with POSIT_DEC_SCALE_EN; out_exp is one constant-zero bit when ES==0.
interface posit_decoder_pipe_if #(
    parameter int N  = 16,
    parameter int ES = 1
);
    localparam int RS = $clog2(N) + 1;
    localparam int FS = N - ES - 3;
    localparam int EW = ES > 0 ? ES : 1;
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic signed [RS-1:0] out_k;
    logic [EW-1:0]        out_exp;
    logic [FS-1:0]        out_frac;
    logic                 out_zero;
    logic                 out_nar;
`ifdef POSIT_DEC_SCALE_EN
    logic signed [RS+ES:0] out_scale;
`endif
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_k, out_exp, out_frac, out_zero, out_nar
`ifdef POSIT_DEC_SCALE_EN
        , out_scale
`endif
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_k, out_exp, out_frac, out_zero, out_nar
`ifdef POSIT_DEC_SCALE_EN
        , out_scale
`endif
    );
endinterface

// File: rtl/posit_decoder_pipe.sv
// posit_decoder_pipe: 3-stage posit<N,ES> decoder (sign, regime k, exponent, fraction, zero/NaR).
// Define POSIT_DEC_SCALE_EN to add out_scale = (k << ES) + exp.
module posit_decoder_pipe #(
    parameter int N  = 16,
    parameter int ES = 1
) (
    input logic clk,
    input logic rst_n,
    posit_decoder_pipe_if.slave bus
);
    localparam int RS = $clog2(N) + 1;
    localparam int FS = N - ES - 3;
    localparam int EW = ES > 0 ? ES : 1;
    localparam int BW = N - 3;
    logic v1, v2, v3, r1, r2, r3;
    logic sign1, zero1, nar1, sign2, zero2, nar2, pol2, sp;
    logic [N-2:0] x1;
    logic [BW-1:0] x2, sh;
    logic [RS-1:0] run, m2;
    logic run_end;
    logic signed [RS-1:0] k;
    logic [EW-1:0] ex;
    logic [FS-1:0] fr;
    assign r3 = !v3 || bus.out_ready;
    assign r2 = !v2 || r3;
    assign r1 = !v1 || r2;
    assign bus.in_ready  = r1;
    assign bus.out_valid = v3;
    always_comb begin
        run     = '0;
        run_end = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            run_end = run_end || (x1[i] != x1[N-2]);
            run     = run + RS'(!run_end);
        end
    end
    // x << (m+1) keeps only bits below the top two, so shift the trimmed body by m-1
    assign sh = x2 << (m2 - RS'(1));
    assign k  = pol2 ? $signed(m2 - RS'(1)) : -$signed(m2);
    assign fr = sh[FS-1:0];
    assign sp = zero2 || nar2;
    if (ES > 0) begin : g_exp
        assign ex = sh[BW-1 -: EW];
    end else begin : g_noexp
        assign ex = '0;
    end
`ifdef POSIT_DEC_SCALE_EN
    localparam int SW = RS + ES + 1;
    logic signed [SW-1:0] sc;
    assign sc = (SW'(k) <<< ES) + SW'(ex);
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {v1, v2, v3, sign1, zero1, nar1, sign2, zero2, nar2, pol2} <= '0;
            x1 <= '0;
            x2 <= '0;
            m2 <= '0;
            bus.out_sign <= 1'b0;
            bus.out_k    <= '0;
            bus.out_exp  <= '0;
            bus.out_frac <= '0;
            bus.out_zero <= 1'b0;
            bus.out_nar  <= 1'b0;
`ifdef POSIT_DEC_SCALE_EN
            bus.out_scale <= '0;
`endif
        end else begin
            if (r1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    sign1 <= bus.in_data[N-1];
                    zero1 <= bus.in_data == '0;
                    nar1  <= bus.in_data == {1'b1, {(N-1){1'b0}}};
                    x1    <= bus.in_data[N-1] ? -bus.in_data[N-2:0] : bus.in_data[N-2:0];
                end
            end
            if (r2) begin
                v2 <= v1;
                if (v1) begin
                    {sign2, zero2, nar2} <= {sign1, zero1, nar1};
                    pol2 <= x1[N-2];
                    m2   <= run;
                    x2   <= x1[BW-1:0];
                end
            end
            if (r3) begin
                v3 <= v2;
                if (v2) begin
                    bus.out_sign <= sign2;
                    bus.out_zero <= zero2;
                    bus.out_nar  <= nar2;
                    bus.out_k    <= sp ? '0 : k;
                    bus.out_exp  <= sp ? '0 : ex;
                    bus.out_frac <= sp ? '0 : fr;
`ifdef POSIT_DEC_SCALE_EN
                    bus.out_scale <= sp ? '0 : sc;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_posit_decoder_pipe.sv
// tb_posit_decoder_pipe: scoreboard bench for posit_decoder_pipe at N=16, ES=1.
module tb_posit_decoder_pipe;
    typedef struct packed {
        logic        sign;
        logic [4:0]  k;
        logic        ex;
        logic [11:0] frac;
        logic        zero;
        logic        nar;
    } res_t;
    logic clk = 1'b0;
    logic rst_n;
    logic take;
    int checks = 0;
    int errors = 0;
    res_t q[$];
    res_t act, pr_data;
    logic pr_rst = 1'b0, pr_v = 1'b0, pr_r = 1'b0;
    logic [15:0] vin [12];
    res_t vexp [12];
    always #5 clk = ~clk;
    posit_decoder_pipe_if #(.N(16), .ES(1)) bus ();
    posit_decoder_pipe #(.N(16), .ES(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign act = {bus.out_sign, bus.out_k, bus.out_exp, bus.out_frac, bus.out_zero, bus.out_nar};
    function automatic res_t mk(input logic s, input int k, input logic e, input logic [11:0] f,
                                input logic z, input logic n);
        return {s, 5'(k), e, f, z, n};
    endfunction
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        bus.in_valid = 1'b0;
        take = 1'b0;
        #1;
    endtask
    task automatic send(input int idx);
        int g;
        @(negedge clk);
        take = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = vin[idx];
        #1;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!bus.in_ready) begin
            $display("FAIL send timeout: word %0h never accepted", vin[idx]);
            $fatal(1, "send timeout");
        end
        take = 1'b1;
        q.push_back(vexp[idx]);
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_left", q.size(), 0);
    endtask
    // Monitor: in_ready against occupancy, stall stability, and in-order results
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (pr_rst && pr_v && !pr_r) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", act, pr_data);
            end
            check("in_ready", bus.in_ready, (int'(q.size()) - int'(take) < 3) || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected output: got %0h expected none", act);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    check("result", act, e);
`ifdef POSIT_DEC_SCALE_EN
                    check("scale", 32'($signed(bus.out_scale)), 32'($signed(e.k) * 2 + int'(e.ex)));
`endif
                end
            end
        end
        pr_rst = rst_n;
        pr_v = bus.out_valid;
        pr_r = bus.out_ready;
        pr_data = act;
    end
    initial begin
        int n;
        vin[0]  = 16'h4000; vexp[0]  = mk(0, 0, 0, 12'h000, 0, 0);
        vin[1]  = 16'h5A5A; vexp[1]  = mk(0, 0, 1, 12'hA5A, 0, 0);
        vin[2]  = 16'hC000; vexp[2]  = mk(1, 0, 0, 12'h000, 0, 0);
        vin[3]  = 16'h7FFF; vexp[3]  = mk(0, 14, 0, 12'h000, 0, 0);
        vin[4]  = 16'h0001; vexp[4]  = mk(0, -14, 0, 12'h000, 0, 0);
        vin[5]  = 16'h2400; vexp[5]  = mk(0, -1, 0, 12'h400, 0, 0);
        vin[6]  = 16'h6800; vexp[6]  = mk(0, 1, 1, 12'h000, 0, 0);
        vin[7]  = 16'h9000; vexp[7]  = mk(1, 2, 0, 12'h000, 0, 0);
        vin[8]  = 16'h1234; vexp[8]  = mk(0, -2, 0, 12'h468, 0, 0);
        vin[9]  = 16'h0000; vexp[9]  = mk(0, 0, 0, 12'h000, 1, 0);
        vin[10] = 16'h8000; vexp[10] = mk(1, 0, 0, 12'h000, 0, 1);
        vin[11] = 16'hFFFF; vexp[11] = mk(1, -14, 0, 12'h000, 0, 0);
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        take = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_outputs", act, 0);
        check("reset_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        send(0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.out_valid && n < 10);
        check("latency", n, 3);
        drain();
        fork
            begin
                for (int i = 1; i <= 8; i++) send(i);
            end
            begin
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        for (int i = 9; i <= 11; i++) send(i);
        drain();
        bus.out_ready = 1'b0;
        for (int i = 3; i <= 5; i++) send(i);
        @(negedge clk);
        bus.in_valid = 1'b0;
        take = 1'b0;
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_outputs", act, 0);
        bus.out_ready = 1'b1;
        send(1);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
